// File: rtl/xadc_pkg.sv
// Shared XADC scheduler definitions: channel/DRP address map, FSM state
// encoding and the raw 16-bit DRP sample type.
package xadc_pkg;

    localparam logic [4:0] CH_TEMP = 5'h00;
    localparam logic [4:0] CH_AUXB = 5'h12;
    localparam logic [4:0] CH_AUXA = 5'h13;

    localparam logic [6:0] ADDR_TEMP = {2'b00, CH_TEMP};
    localparam logic [6:0] ADDR_AUX2 = {2'b00, CH_AUXB};
    localparam logic [6:0] ADDR_AUX3 = {2'b00, CH_AUXA};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_STORE = 2'd3
    } state_e;

    typedef logic [15:0] sample_t;

    function automatic logic is_mapped(input logic [4:0] ch);
        return (ch == CH_TEMP) || (ch == CH_AUXB) || (ch == CH_AUXA);
    endfunction

endpackage

// File: rtl/xadc_avg4.sv
// Per-channel 4-sample mean: keeps the previous three samples and, on the
// push that brings the history to four, registers (sum of four) >> 2.
module xadc_avg4
    import xadc_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    i_push,
    input  sample_t i_data,
    output sample_t o_avg,
    output logic    o_upd
);

    sample_t     r_s0;
    sample_t     r_s1;
    sample_t     r_s2;
    logic [1:0]  r_cnt;
    sample_t     r_avg;
    logic [17:0] w_sum;

    assign w_sum = 18'(r_s0) + 18'(r_s1) + 18'(r_s2) + 18'(i_data);
    assign o_upd = i_push && (r_cnt == 2'd3);
    assign o_avg = r_avg;

    // sample history, fill count and averaged result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0  <= 16'h0000;
            r_s1  <= 16'h0000;
            r_s2  <= 16'h0000;
            r_cnt <= 2'd0;
            r_avg <= 16'h0000;
        end else if (i_push) begin
            r_s2 <= r_s1;
            r_s1 <= r_s0;
            r_s0 <= i_data;
            if (r_cnt != 2'd3) begin
                r_cnt <= r_cnt + 2'd1;
            end
            if (o_upd) begin
                r_avg <= w_sum[17:2];
            end
        end
    end

endmodule

// File: rtl/xadc_drp_sched.sv
// XADC end-of-conversion driven DRP read scheduler with one-deep pending slot.
// Optional build macro XADC_SCHED_AVG_EN replaces raw results with 4-sample means.
module xadc_drp_sched
    import xadc_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic       DCLK,
    input  logic       RESET,
    input  logic       eoc_in,
    input  logic [4:0] channel_in,
    output logic       drp_den,
    output logic [6:0] drp_daddr,
    output logic       drp_dwe,
    input  sample_t    drp_do,
    input  logic       drp_drdy,
    input  logic       sel,
    output sample_t    temp_out,
    output sample_t    aux_a_out,
    output sample_t    aux_b_out,
    output sample_t    aux_sel_out,
    output logic       sample_valid,
    output logic       busy,
    output logic       ovr_err,
    output logic       tmo_err
);

    localparam int             CW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0]  TMO_LAST = CW'(TIMEOUT_CYC - 1);

    state_e        r_state;
    state_e        w_state_nxt;
    logic [4:0]    r_chan;
    logic          r_pend;
    logic [4:0]    r_pend_ch;
    logic [CW-1:0] r_tmo_cnt;
    logic          r_den;
    logic          r_busy;
    logic          r_sv;
    logic          r_ovr;
    logic          r_tmo;

    logic w_eoc_mapped;
    logic w_take_pend;
    logic w_take_eoc;
    logic w_accept;
    logic w_tmo;
    logic w_wr_temp;
    logic w_wr_auxa;
    logic w_wr_auxb;
    logic w_sv_set;

    assign w_eoc_mapped = eoc_in && is_mapped(channel_in);
    assign w_accept     = (r_state == ST_WAIT) && drp_drdy;
    assign w_tmo        = (r_state == ST_WAIT) && !drp_drdy && (r_tmo_cnt == TMO_LAST);
    assign w_wr_temp    = w_accept && (drp_daddr == ADDR_TEMP);
    assign w_wr_auxb    = w_accept && (drp_daddr == ADDR_AUX2);
    assign w_wr_auxa    = w_accept && (drp_daddr == ADDR_AUX3);

    // next-state decode; a pending request wins over a fresh EOC in IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_take_pend = 1'b0;
        w_take_eoc  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_pend) begin
                    w_state_nxt = ST_ISSUE;
                    w_take_pend = 1'b1;
                end else if (w_eoc_mapped) begin
                    w_state_nxt = ST_ISSUE;
                    w_take_eoc  = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (drp_drdy) begin
                    w_state_nxt = ST_STORE;
                end else if (w_tmo) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_STORE: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge DCLK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // request capture, pending slot, timeout counter and status flags
    always_ff @(posedge DCLK) begin
        if (RESET) begin
            r_chan    <= 5'h00;
            r_pend    <= 1'b0;
            r_pend_ch <= 5'h00;
            r_tmo_cnt <= '0;
            r_den     <= 1'b0;
            r_busy    <= 1'b0;
            r_sv      <= 1'b0;
            r_ovr     <= 1'b0;
            r_tmo     <= 1'b0;
        end else begin
            if (w_take_pend) begin
                r_chan <= r_pend_ch;
            end else if (w_take_eoc) begin
                r_chan <= channel_in;
            end
            if (w_take_pend) begin
                r_pend    <= w_eoc_mapped;
                r_pend_ch <= w_eoc_mapped ? channel_in : r_pend_ch;
            end else if (w_eoc_mapped && !w_take_eoc) begin
                r_pend    <= 1'b1;
                r_pend_ch <= channel_in;
                if (r_pend) begin
                    r_ovr <= 1'b1;
                end
            end
            r_tmo_cnt <= (r_state == ST_WAIT) ? r_tmo_cnt + CW'(1) : '0;
            if (w_tmo) begin
                r_tmo <= 1'b1;
            end
            r_den  <= (w_state_nxt == ST_ISSUE);
            r_busy <= (w_state_nxt != ST_IDLE);
            r_sv   <= w_sv_set;
        end
    end

`ifdef XADC_SCHED_AVG_EN
    logic w_upd_temp;
    logic w_upd_auxa;
    logic w_upd_auxb;

    xadc_avg4 u_avg_temp (
        .clk    (DCLK),
        .rst    (RESET),
        .i_push (w_wr_temp),
        .i_data (drp_do),
        .o_avg  (temp_out),
        .o_upd  (w_upd_temp)
    );

    xadc_avg4 u_avg_auxa (
        .clk    (DCLK),
        .rst    (RESET),
        .i_push (w_wr_auxa),
        .i_data (drp_do),
        .o_avg  (aux_a_out),
        .o_upd  (w_upd_auxa)
    );

    xadc_avg4 u_avg_auxb (
        .clk    (DCLK),
        .rst    (RESET),
        .i_push (w_wr_auxb),
        .i_data (drp_do),
        .o_avg  (aux_b_out),
        .o_upd  (w_upd_auxb)
    );

    assign w_sv_set = w_upd_temp || w_upd_auxa || w_upd_auxb;
`else
    sample_t r_temp;
    sample_t r_auxa;
    sample_t r_auxb;

    // results land on the WAIT->STORE edge so they are visible during STORE
    always_ff @(posedge DCLK) begin
        if (RESET) begin
            r_temp <= 16'h0000;
            r_auxa <= 16'h0000;
            r_auxb <= 16'h0000;
        end else begin
            if (w_wr_temp) begin
                r_temp <= drp_do;
            end
            if (w_wr_auxa) begin
                r_auxa <= drp_do;
            end
            if (w_wr_auxb) begin
                r_auxb <= drp_do;
            end
        end
    end

    assign temp_out  = r_temp;
    assign aux_a_out = r_auxa;
    assign aux_b_out = r_auxb;
    assign w_sv_set  = w_accept;
`endif

    assign drp_den      = r_den;
    assign drp_daddr    = {2'b00, r_chan};
    assign drp_dwe      = 1'b0;
    assign aux_sel_out  = sel ? aux_a_out : aux_b_out;
    assign sample_valid = r_sv;
    assign busy         = r_busy;
    assign ovr_err      = r_ovr;
    assign tmo_err      = r_tmo;

endmodule

// File: tb/tb_xadc_drp_sched.sv
// Scoreboard bench for xadc_drp_sched: a DRP responder queues expected results,
// a monitor pops them on every sample_valid pulse.
module tb_xadc_drp_sched;

    typedef struct {
        int          dly;
        logic [15:0] data;
        bit          exp_sv;
        logic [15:0] exp_val;
    } rsp_t;

    typedef struct {
        logic [4:0]  ch;
        logic [15:0] val;
    } res_t;

    logic        DCLK = 1'b0;
    logic        RESET;
    logic        eoc_in;
    logic [4:0]  channel_in;
    logic        drp_den;
    logic [6:0]  drp_daddr;
    logic        drp_dwe;
    logic [15:0] drp_do;
    logic        drp_drdy;
    logic        sel;
    logic [15:0] temp_out;
    logic [15:0] aux_a_out;
    logic [15:0] aux_b_out;
    logic [15:0] aux_sel_out;
    logic        sample_valid;
    logic        busy;
    logic        ovr_err;
    logic        tmo_err;

    logic        rsp_drdy  = 1'b0;
    logic [15:0] rsp_do    = 16'h0000;
    logic        stray_drdy = 1'b0;
    logic [15:0] stray_do   = 16'h0000;

    rsp_t        rsp_q[$];
    logic [6:0]  addr_q[$];
    res_t        sb_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int den_cnt  = 0;
    int sv_cnt   = 0;
    logic prev_den = 1'b0;

    assign drp_drdy = rsp_drdy | stray_drdy;
    assign drp_do   = rsp_drdy ? rsp_do : stray_do;

    always #5 DCLK = ~DCLK;

    xadc_drp_sched #(.TIMEOUT_CYC(64)) dut (
        .DCLK         (DCLK),
        .RESET        (RESET),
        .eoc_in       (eoc_in),
        .channel_in   (channel_in),
        .drp_den      (drp_den),
        .drp_daddr    (drp_daddr),
        .drp_dwe      (drp_dwe),
        .drp_do       (drp_do),
        .drp_drdy     (drp_drdy),
        .sel          (sel),
        .temp_out     (temp_out),
        .aux_a_out    (aux_a_out),
        .aux_b_out    (aux_b_out),
        .aux_sel_out  (aux_sel_out),
        .sample_valid (sample_valid),
        .busy         (busy),
        .ovr_err      (ovr_err),
        .tmo_err      (tmo_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        n_errors++;
        $display("FAIL %s", nm);
    endtask

    task automatic tick();
        @(posedge DCLK);
        #1;
    endtask

    task automatic pulse_eoc(input logic [4:0] ch);
        eoc_in     = 1'b1;
        channel_in = ch;
        tick();
        eoc_in     = 1'b0;
        channel_in = 5'h00;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        @(negedge DCLK);
        while ((busy || rsp_q.size() != 0 || sb_q.size() != 0) && n < 300) begin
            n++;
            @(negedge DCLK);
        end
        if (n >= 300) fail_now({nm, "_idle_timeout"});
        tick();
    endtask

    // DRP slave model: checks each access address and answers per the response queue
    initial begin
        rsp_t       r;
        logic [6:0] ea;
        forever begin
            @(negedge DCLK);
            if (drp_den === 1'b1) begin
                if (addr_q.size() == 0 || rsp_q.size() == 0) begin
                    fail_now("den_unexpected");
                end else begin
                    ea = addr_q.pop_front();
                    r  = rsp_q.pop_front();
                    chk("drp_daddr", drp_daddr, ea);
                    if (r.dly > 0) begin
                        repeat (r.dly) @(posedge DCLK);
                        #1;
                        rsp_drdy = 1'b1;
                        rsp_do   = r.data;
                        if (r.exp_sv) sb_q.push_back('{ea[4:0], r.exp_val});
                        @(posedge DCLK);
                        #1;
                        rsp_drdy = 1'b0;
                    end
                end
            end
        end
    end

    // monitor: result scoreboard, den pulse width, event counters
    initial begin
        res_t res;
        forever begin
            @(negedge DCLK);
            if (drp_den === 1'b1) begin
                den_cnt++;
                chk("den_single_cycle", prev_den, 1'b0);
            end
            prev_den = drp_den;
            if (sample_valid === 1'b1) begin
                sv_cnt++;
                if (sb_q.size() == 0) begin
                    fail_now("sample_valid_unexpected");
                end else begin
                    res = sb_q.pop_front();
                    case (res.ch)
                        5'h00:   chk("temp_out", temp_out, res.val);
                        5'h12:   chk("aux_b_out", aux_b_out, res.val);
                        5'h13:   chk("aux_a_out", aux_a_out, res.val);
                        default: fail_now("scoreboard_channel");
                    endcase
                end
            end
        end
    end

    initial begin
        #2000000;
        fail_now("watchdog");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int d0;
        int s0;
        RESET      = 1'b1;
        eoc_in     = 1'b0;
        channel_in = 5'h00;
        sel        = 1'b0;
        repeat (3) tick();
        @(negedge DCLK);
        chk("rst_temp", temp_out, 16'h0000);
        chk("rst_aux_a", aux_a_out, 16'h0000);
        chk("rst_aux_b", aux_b_out, 16'h0000);
        chk("rst_den", drp_den, 1'b0);
        chk("rst_dwe", drp_dwe, 1'b0);
        chk("rst_sv", sample_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ovr", ovr_err, 1'b0);
        chk("rst_tmo", tmo_err, 1'b0);
        tick();
        RESET = 1'b0;
        tick();

`ifdef XADC_SCHED_AVG_EN
        begin
            logic [15:0] din [4];
            logic [15:0] dexp[4];
            din  = '{16'h1000, 16'h2000, 16'h3000, 16'h4000};
            dexp = '{16'h0000, 16'h0000, 16'h0000, 16'h2800};
            for (int i = 0; i < 4; i++) begin
                addr_q.push_back(7'h12);
                rsp_q.push_back('{2, din[i], (i == 3), dexp[i]});
                pulse_eoc(5'h12);
                wait_idle("avg");
                chk("avg_aux_b", aux_b_out, dexp[i]);
            end
            chk("avg_sv_count", sv_cnt, 1);
        end
`else
        // AUX_A read, drdy three cycles after den, latency EOC->valid of 5
        sel = 1'b1;
        d0  = den_cnt;
        s0  = sv_cnt;
        addr_q.push_back(7'h13);
        rsp_q.push_back('{3, 16'hE3E0, 1'b1, 16'hE3E0});
        pulse_eoc(5'h13);
        lat = 1;
        @(negedge DCLK);
        while (!sample_valid && lat < 50) begin
            lat++;
            @(negedge DCLK);
        end
        chk("latency", lat, 5);
        wait_idle("auxa");
        chk("auxa_value", aux_a_out, 16'hE3E0);
        chk("aux_sel_a", aux_sel_out, 16'hE3E0);
        chk("auxa_den_count", den_cnt - d0, 1);
        chk("auxa_sv_count", sv_cnt - s0, 1);
        sel = 1'b0;
        #1;
        chk("aux_sel_b", aux_sel_out, 16'h0000);

        // unmapped channel produces no access
        d0 = den_cnt;
        pulse_eoc(5'h05);
        for (int i = 0; i < 3; i++) begin
            @(negedge DCLK);
            chk("unmapped_busy", busy, 1'b0);
        end
        tick();
        chk("unmapped_den_count", den_cnt - d0, 0);
        chk("unmapped_aux_a", aux_a_out, 16'hE3E0);
        chk("unmapped_temp", temp_out, 16'h0000);

        // temp, then AUX_B overwritten in the pending slot by AUX_A
        d0 = den_cnt;
        addr_q.push_back(7'h00);
        addr_q.push_back(7'h13);
        rsp_q.push_back('{2, 16'h1230, 1'b1, 16'h1230});
        rsp_q.push_back('{2, 16'h4560, 1'b1, 16'h4560});
        pulse_eoc(5'h00);
        pulse_eoc(5'h12);
        pulse_eoc(5'h13);
        wait_idle("ovr");
        chk("ovr_temp", temp_out, 16'h1230);
        chk("ovr_aux_a", aux_a_out, 16'h4560);
        chk("ovr_aux_b", aux_b_out, 16'h0000);
        chk("ovr_err", ovr_err, 1'b1);
        chk("ovr_den_count", den_cnt - d0, 2);

        // no drdy: abort after 64 WAIT cycles
        addr_q.push_back(7'h12);
        rsp_q.push_back('{-1, 16'h0000, 1'b0, 16'h0000});
        chk("tmo_before", tmo_err, 1'b0);
        pulse_eoc(5'h12);
        lat = 1;
        @(negedge DCLK);
        while (!tmo_err && lat < 200) begin
            lat++;
            @(negedge DCLK);
        end
        chk("tmo_cycles", lat, 66);
        chk("tmo_busy", busy, 1'b0);
        chk("tmo_aux_b", aux_b_out, 16'h0000);
        tick();

        // drdy while IDLE is ignored
        stray_do   = 16'hBEEF;
        stray_drdy = 1'b1;
        tick();
        stray_drdy = 1'b0;
        repeat (3) tick();
        chk("stray_temp", temp_out, 16'h1230);
        chk("stray_aux_b", aux_b_out, 16'h0000);
        chk("stray_busy", busy, 1'b0);

        // EOC during STORE becomes pending and is serviced next
        d0 = den_cnt;
        addr_q.push_back(7'h00);
        addr_q.push_back(7'h12);
        rsp_q.push_back('{1, 16'hAAA0, 1'b1, 16'hAAA0});
        rsp_q.push_back('{1, 16'hBBB0, 1'b1, 16'hBBB0});
        pulse_eoc(5'h00);
        tick();
        tick();
        chk("store_cycle_sv", sample_valid, 1'b1);
        pulse_eoc(5'h12);
        wait_idle("store_eoc");
        chk("store_eoc_temp", temp_out, 16'hAAA0);
        chk("store_eoc_aux_b", aux_b_out, 16'hBBB0);
        chk("store_eoc_den_count", den_cnt - d0, 2);

        // reset in WAIT, late drdy two cycles later
        s0 = sv_cnt;
        addr_q.push_back(7'h13);
        rsp_q.push_back('{3, 16'h7770, 1'b0, 16'h0000});
        pulse_eoc(5'h13);
        tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        repeat (4) tick();
        chk("rstmid_temp", temp_out, 16'h0000);
        chk("rstmid_aux_a", aux_a_out, 16'h0000);
        chk("rstmid_aux_b", aux_b_out, 16'h0000);
        chk("rstmid_ovr", ovr_err, 1'b0);
        chk("rstmid_tmo", tmo_err, 1'b0);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_sv_count", sv_cnt - s0, 0);
`endif

        chk("sb_empty", sb_q.size(), 0);
        chk("rsp_empty", rsp_q.size(), 0);
        chk("addr_empty", addr_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
